// File: rtl/reg_file_pkg.sv
// Shared constants and types for the renaming register file.
// Widths, index type and boolean constants used by reg_file and its read ports.
package reg_file_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int ROB_W_DEF = 4;
    localparam int IDX_W     = 5;
    localparam int NUM_REGS  = 32;
    localparam int CNT_W     = 6;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef logic [IDX_W-1:0] idx_t;

    // x0 is hardwired: nothing may write it or mark it busy
    function automatic logic idx_live(input idx_t idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Read, rename and commit bundle between decode/ROB (master) and reg_file (slave).
// Busy count travels back to the master alongside the read results.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int ROB_W = ROB_W_DEF
) ();

    idx_t             rs1_idx;
    idx_t             rs2_idx;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    logic             rs1_busy;
    logic             rs2_busy;
    logic [ROB_W-1:0] rs1_tag;
    logic [ROB_W-1:0] rs2_tag;

    logic             ren_en;
    idx_t             ren_rd;
    logic [ROB_W-1:0] ren_tag;

    logic             cmt_en;
    idx_t             cmt_rd;
    logic [ROB_W-1:0] cmt_tag;
    logic [XLEN-1:0]  cmt_val;

    logic             flush;
    logic [CNT_W-1:0] busy_cnt;

    modport master (
        output rs1_idx, rs2_idx, ren_en, ren_rd, ren_tag,
               cmt_en, cmt_rd, cmt_tag, cmt_val, flush,
        input  rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag, busy_cnt
    );

    modport slave (
        input  rs1_idx, rs2_idx, ren_en, ren_rd, ren_tag,
               cmt_en, cmt_rd, cmt_tag, cmt_val, flush,
        output rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag, busy_cnt
    );

endinterface

// File: rtl/reg_file_read_port.sv
// Purpose: one combinational register read (value, busy, tag) with optional commit bypass (RF_BYPASS_EN).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the read is always valid.
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int ROB_W = ROB_W_DEF
) (
    input  idx_t                             idx,
    input  logic [NUM_REGS-1:0][XLEN-1:0]    vals,
    input  logic [NUM_REGS-1:0]              busy,
    input  logic [NUM_REGS-1:0][ROB_W-1:0]   tags,
`ifdef RF_BYPASS_EN
    input  logic                             byp_hit,
    input  idx_t                             byp_rd,
    input  logic [XLEN-1:0]                  byp_val,
`endif
    output logic [XLEN-1:0]                  rd_val,
    output logic                             rd_busy,
    output logic [ROB_W-1:0]                 rd_tag
);

    always_comb begin
        rd_val  = vals[idx];
        rd_busy = busy[idx];
        rd_tag  = tags[idx];
`ifdef RF_BYPASS_EN
        // byp_hit already implies a live, busy, tag-matching commit
        if (byp_hit && (idx == byp_rd)) begin
            rd_val  = byp_val;
            rd_busy = FALSE;
        end
`endif
    end

endmodule

// File: rtl/reg_file.sv
// Purpose: 32-entry architectural register file with per-register ROB rename tags; RF_BYPASS_EN adds commit bypass.
// Latency: reads combinational; rename/commit/flush take effect on the next rising edge.
// Backpressure: none; rdy low freezes all state and ignores rename, commit and flush.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int ROB_W = ROB_W_DEF,
    parameter int XLEN  = XLEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    reg_file_if.slave  rf
);

    logic [NUM_REGS-1:0][XLEN-1:0]  vals_q;
    logic [NUM_REGS-1:0]            busy_q;
    logic [NUM_REGS-1:0][ROB_W-1:0] tags_q;
    logic [CNT_W-1:0]               cnt_q;

    logic cmt_act;
    logic cmt_hit;
    logic cmt_clr;
    logic ren_act;
    logic ren_new;
    logic flush_act;

    always_comb begin
        cmt_act   = rdy & rf.cmt_en & idx_live(rf.cmt_rd);
        cmt_hit   = cmt_act & busy_q[rf.cmt_rd] & (tags_q[rf.cmt_rd] == rf.cmt_tag);
        ren_act   = rdy & rf.ren_en & ~rf.flush & idx_live(rf.ren_rd);
        ren_new   = ren_act & ~busy_q[rf.ren_rd];
        // a same-register rename keeps the entry busy under its new tag
        cmt_clr   = cmt_hit & ~(ren_act & (rf.ren_rd == rf.cmt_rd));
        flush_act = rdy & rf.flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vals_q <= '0;
        end else if (cmt_act) begin
            vals_q[rf.cmt_rd] <= rf.cmt_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            tags_q <= '0;
        end else if (flush_act) begin
            busy_q <= '0;
        end else begin
            if (cmt_clr) begin
                busy_q[rf.cmt_rd] <= FALSE;
            end
            if (ren_act) begin
                busy_q[rf.ren_rd] <= TRUE;
                tags_q[rf.ren_rd] <= rf.ren_tag;
            end
        end
    end

    // Incremental popcount: never exceeds 31 since x0 cannot be busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (flush_act) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(ren_new) - CNT_W'(cmt_clr);
        end
    end

    assign rf.busy_cnt = cnt_q;

    rf_read_port #(.XLEN(XLEN), .ROB_W(ROB_W)) u_rd1 (
        .idx     (rf.rs1_idx),
        .vals    (vals_q),
        .busy    (busy_q),
        .tags    (tags_q),
`ifdef RF_BYPASS_EN
        .byp_hit (cmt_hit),
        .byp_rd  (rf.cmt_rd),
        .byp_val (rf.cmt_val),
`endif
        .rd_val  (rf.rs1_val),
        .rd_busy (rf.rs1_busy),
        .rd_tag  (rf.rs1_tag)
    );

    rf_read_port #(.XLEN(XLEN), .ROB_W(ROB_W)) u_rd2 (
        .idx     (rf.rs2_idx),
        .vals    (vals_q),
        .busy    (busy_q),
        .tags    (tags_q),
`ifdef RF_BYPASS_EN
        .byp_hit (cmt_hit),
        .byp_rd  (rf.cmt_rd),
        .byp_val (rf.cmt_val),
`endif
        .rd_val  (rf.rs2_val),
        .rd_busy (rf.rs2_busy),
        .rd_tag  (rf.rs2_tag)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios then random traffic against an array model.
module tb_reg_file;
    import reg_file_pkg::*;

    localparam int XLEN  = 32;
    localparam int ROB_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b0;
    int   errors = 0;
    int   checks = 0;

    reg_file_if #(.XLEN(XLEN), .ROB_W(ROB_W)) rf ();

    reg_file #(.ROB_W(ROB_W), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .rf  (rf)
    );

    always #5 clk = ~clk;

    // Architectural model: plain arrays updated by the rename/commit/flush rules
    logic [XLEN-1:0]  m_val  [32];
    bit               m_busy [32];
    logic [ROB_W-1:0] m_tag  [32];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
    endtask

    task automatic model_edge();
        bit match;
        if (!rdy) return;
        if (rf.cmt_en && rf.cmt_rd != 0) begin
            match = m_busy[rf.cmt_rd] && (m_tag[rf.cmt_rd] == rf.cmt_tag);
            m_val[rf.cmt_rd] = rf.cmt_val;
            if (match) m_busy[rf.cmt_rd] = 1'b0;
        end
        if (rf.flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (rf.ren_en && rf.ren_rd != 0) begin
            m_busy[rf.ren_rd] = 1'b1;
            m_tag[rf.ren_rd]  = rf.ren_tag;
        end
    endtask

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic void exp_read(input idx_t idx, output logic [XLEN-1:0] v,
                                     output logic b, output logic [ROB_W-1:0] t);
        v = m_val[idx];
        b = m_busy[idx];
        t = m_tag[idx];
`ifdef RF_BYPASS_EN
        if (rdy && rf.cmt_en && idx != 0 && idx == rf.cmt_rd && m_busy[idx] && m_tag[idx] == rf.cmt_tag) begin
            v = rf.cmt_val;
            b = 1'b0;
        end
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic set_idle();
        rdy        = 1'b1;
        rf.ren_en  = 1'b0;
        rf.ren_rd  = '0;
        rf.ren_tag = '0;
        rf.cmt_en  = 1'b0;
        rf.cmt_rd  = '0;
        rf.cmt_tag = '0;
        rf.cmt_val = '0;
        rf.flush   = 1'b0;
    endtask

    task automatic ren(input int rd, input int tag);
        rf.ren_en  = 1'b1;
        rf.ren_rd  = IDX_W'(rd);
        rf.ren_tag = ROB_W'(tag);
    endtask

    task automatic cmt(input int rd, input int tag, input logic [XLEN-1:0] val);
        rf.cmt_en  = 1'b1;
        rf.cmt_rd  = IDX_W'(rd);
        rf.cmt_tag = ROB_W'(tag);
        rf.cmt_val = val;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        set_idle();
    endtask

    task automatic check_all(input string name);
        logic [XLEN-1:0]  v;
        logic             b;
        logic [ROB_W-1:0] t;
        #1;
        exp_read(rf.rs1_idx, v, b, t);
        chk({name, ".rs1_val"},  rf.rs1_val,  v);
        chk({name, ".rs1_busy"}, rf.rs1_busy, b);
        chk({name, ".rs1_tag"},  rf.rs1_tag,  t);
        exp_read(rf.rs2_idx, v, b, t);
        chk({name, ".rs2_val"},  rf.rs2_val,  v);
        chk({name, ".rs2_busy"}, rf.rs2_busy, b);
        chk({name, ".rs2_tag"},  rf.rs2_tag,  t);
        chk({name, ".busy_cnt"}, rf.busy_cnt, model_cnt());
    endtask

    initial begin
        set_idle();
        rf.rs1_idx = 5'd5;
        rf.rs2_idx = 5'd0;
        model_reset();

        // Reset state
        #12;
        chk("rst.rs1_val",  rf.rs1_val,  0);
        chk("rst.rs1_busy", rf.rs1_busy, 0);
        chk("rst.busy_cnt", rf.busy_cnt, 0);
        rst = 1'b1;
        tick();

        // Rename then matching commit
        ren(5, 3);
        check_all("ren5");
        tick();
        check_all("ren5_post");
        chk("ren5.busy", rf.rs1_busy, 1);
        chk("ren5.tag",  rf.rs1_tag,  3);
        chk("ren5.cnt",  rf.busy_cnt, 1);
        cmt(5, 3, 32'hDEADBEEF);
        check_all("cmt5_pre");
        tick();
        check_all("cmt5_post");
        chk("cmt5.val",  rf.rs1_val,  32'hDEADBEEF);
        chk("cmt5.busy", rf.rs1_busy, 0);
        chk("cmt5.cnt",  rf.busy_cnt, 0);

        // Stale-tag commit after re-rename
        rf.rs1_idx = 5'd7;
        ren(7, 2); tick();
        ren(7, 9); tick();
        cmt(7, 2, 32'h11);
        check_all("stale_pre");
        tick();
        check_all("stale_post");
        chk("stale.val",  rf.rs1_val,  32'h11);
        chk("stale.busy", rf.rs1_busy, 1);
        chk("stale.tag",  rf.rs1_tag,  9);
        chk("stale.cnt",  rf.busy_cnt, 1);

        // Same-cycle rename and commit on one register
        rf.rs1_idx = 5'd4;
        ren(4, 1); tick();
        ren(4, 6); cmt(4, 1, 32'h44);
        check_all("same_pre");
        tick();
        check_all("same_post");
        chk("same.busy", rf.rs1_busy, 1);
        chk("same.tag",  rf.rs1_tag,  6);
        chk("same.val",  rf.rs1_val,  32'h44);
        chk("same.cnt",  rf.busy_cnt, 2);

        // Flush with concurrent commit, then x0 rename
        ren(1, 10); tick();
        ren(2, 11); tick();
        ren(3, 12); tick();
        rf.rs1_idx = 5'd2;
        rf.rs2_idx = 5'd3;
        rf.flush = 1'b1; cmt(2, 0, 32'h42); ren(6, 4);
        check_all("flush_pre");
        tick();
        check_all("flush_post");
        chk("flush.cnt", rf.busy_cnt, 0);
        chk("flush.x2",  rf.rs1_val,  32'h42);
        rf.rs1_idx = 5'd0;
        ren(0, 7); tick();
        check_all("x0");
        chk("x0.busy", rf.rs1_busy, 0);
        chk("x0.val",  rf.rs1_val,  0);

        // Commit visibility on the read port
        ren(8, 5); tick();
        rf.rs2_idx = 5'd8;
        cmt(8, 5, 32'h99);
        check_all("byp_pre");
`ifdef RF_BYPASS_EN
        chk("byp.val",  rf.rs2_val,  32'h99);
        chk("byp.busy", rf.rs2_busy, 0);
`else
        chk("nobyp.busy", rf.rs2_busy, 1);
        chk("nobyp.val",  rf.rs2_val,  0);
`endif
        tick();
        check_all("byp_post");
        chk("byp_post.val",  rf.rs2_val,  32'h99);
        chk("byp_post.busy", rf.rs2_busy, 0);

        // rdy low freezes everything
        rf.rs1_idx = 5'd9;
        ren(9, 1); tick();
        rdy = 1'b0; cmt(9, 1, 32'h77); rf.flush = 1'b1; ren(10, 2);
        check_all("hold_pre");
        chk("hold_pre.busy", rf.rs1_busy, 1);
        tick();
        check_all("hold_post");
        chk("hold.busy", rf.rs1_busy, 1);
        chk("hold.val",  rf.rs1_val,  0);
        chk("hold.cnt",  rf.busy_cnt, 1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int rd;
            rdy        = ($urandom_range(0, 9) != 0);
            rf.rs1_idx = IDX_W'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
            rf.rs2_idx = IDX_W'($urandom_range(0, 7));
            rf.flush   = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 1) == 1) ren(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) begin
                rd = int'($urandom_range(0, 7));
                cmt(rd, ($urandom_range(0, 3) != 0) ? int'(m_tag[rd]) : int'($urandom_range(0, 15)), $urandom);
            end
            check_all("rand");
            tick();
        end

        // Asynchronous reset mid-operation with rename/commit pending
        rf.rs1_idx = 5'd5;
        ren(3, 3); cmt(5, 0, 32'h1234);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("arst.cnt",  rf.busy_cnt, 0);
        chk("arst.val",  rf.rs1_val,  0);
        chk("arst.busy", rf.rs1_busy, 0);
        tick();
        set_idle();
        rst = 1'b1;
        check_all("arst_rel");
        tick();
        check_all("arst_idle");
        rf.rs1_idx = 5'd3;
        ren(3, 14); tick();
        check_all("arst_resume");
        chk("resume.cnt", rf.busy_cnt, 1);
        chk("resume.tag", rf.rs1_tag,  14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter ROB_W, default 4, meaning reorder-tag width (16-entry ROB).
REQ-002 SHALL have parameter XLEN, default 32, meaning architectural register width.
REQ-003 SHALL have ports:
  clk            in   1       single clock, all state on rising edge
  rst            in   1       asynchronous, active-low reset
  rdy            in   1       global enable; low = hold all state
  rs1_idx        in   5       source-1 register index
  rs2_idx        in   5       source-2 register index
  rs1_val        out  XLEN    source-1 value
  rs1_busy       out  1       source-1 awaits a ROB result
  rs1_tag        out  ROB_W   source-1 producing ROB entry
  rs2_val/rs2_busy/rs2_tag    out  as rs1_*   source-2 equivalents
  ren_en         in   1       decode renames a destination this cycle
  ren_rd         in   5       destination register
  ren_tag        in   ROB_W   ROB entry allocated to it
  cmt_en         in   1       ROB commits an entry this cycle
  cmt_rd         in   5       committed destination
  cmt_tag        in   ROB_W   committed ROB entry (ROB front)
  cmt_val        in   XLEN    committed value
  flush          in   1       mispredict; discard all renames
  busy_cnt       out  6       number of registers currently busy

Function
REQ-004 SHALL hold 32 x XLEN values plus per-register busy bit and ROB_W tag; x0 reads 0, never busy, never written.
REQ-005 SHALL drive rs*_val/busy/tag combinationally from the indices (zero-cycle read latency).
REQ-006 On rising edge with rdy=1 and cmt_en=1, cmt_rd!=0: SHALL write cmt_val to cmt_rd regardless of tag.
REQ-007 Commit SHALL clear busy of cmt_rd only if stored tag == cmt_tag and busy=1; stale-tag commit leaves busy/tag untouched.
REQ-008 On rising edge with rdy=1, ren_en=1, ren_rd!=0, flush=0: SHALL set busy=1, tag=ren_tag.
REQ-009 Rename and commit to same register same cycle: rename wins for busy/tag; value still written.
REQ-010 flush=1 (rdy=1): SHALL clear every busy bit next edge; commit value write in that cycle still occurs; ren_en ignored.
REQ-011 rdy=0: SHALL ignore ren_en, cmt_en, flush; all state held; reads still valid.
REQ-012 busy_cnt SHALL be a register equal to the popcount of busy bits after each edge (range 0..31), updated incrementally (+1 rename of non-busy reg, -1 matching commit, net 0 when both on different regs cancel), zeroed by flush.
REQ-013 Renaming an already-busy register SHALL overwrite tag without changing busy_cnt.

Reset
REQ-014 rst=0 SHALL immediately clear all values to 0, all busy bits to 0, all tags to 0, busy_cnt to 0, independent of clk and rdy.
REQ-015 Reset deasserted mid-operation SHALL resume on next edge with no pending rename/commit retained.

Configuration
REQ-016 Macro RF_BYPASS_EN defined: if cmt_en=1, rdy=1, rs*_idx==cmt_rd!=0, stored tag==cmt_tag and busy, SHALL output rs*_val=cmt_val, rs*_busy=0 same cycle.
REQ-017 RF_BYPASS_EN undefined: reads SHALL reflect registered state only; result visible one cycle after commit.

Structure
REQ-018 XLEN, ROB_W, register-index width and True/False constants SHALL live in the shared defines header.
REQ-019 Read-port lookup plus bypass mux SHALL be sub-module rf_read_port, instantiated twice.

Verification
REQ-020 Reset then rs1_idx=5 -> rs1_val=0, rs1_busy=0, busy_cnt=0.
REQ-021 ren x5 tag 3; next cycle rs1_idx=5 -> busy=1, tag=3; commit x5 tag 3 val 0xDEADBEEF -> busy=0, val=0xDEADBEEF, busy_cnt 1->0.
REQ-022 ren x7 tag 2, ren x7 tag 9, commit x7 tag 2 val 0x11 -> val=0x11, busy=1, tag=9, busy_cnt=1.
REQ-023 Same-cycle ren x4 tag 6 and commit x4 tag 1 (x4 busy tag 1) -> busy=1, tag=6, value written, busy_cnt unchanged.
REQ-024 ren x1,x2,x3 then flush with commit x2 val 0x42 -> all busy=0, busy_cnt=0, x2=0x42; ren x0 -> x0 never busy.
REQ-025 With RF_BYPASS_EN: commit x8 tag 5 val 0x99 while rs2_idx=8 -> rs2_val=0x99, rs2_busy=0 same cycle; without macro -> busy=1 that cycle, 0x99 next cycle; rdy=0 during commit -> no change.
